fib_req_ctrl: RTL and testbench
===============================

# fib_req_ctrl

Request/response front-end for the Fibonacci generator. Accepts index requests over a valid/ready interface, queues them in a small FIFO, and sequences the generator one request at a time: reset, launch, wait for `data_ready`. Returns each result with its index and tag over a second valid/ready interface. Sits directly upstream of the generator and owns its `rst` and `n` inputs. Requests with n < 2 are handled locally, because the generator does not support them.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥ 2.
- `TAG_W`, 4: width of the opaque request tag.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; `!full`.
- `req_n` in 8: Fibonacci index n.
- `req_tag` in TAG_W: returned unchanged with the result.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts result.
- `res_fib` out 32: F(n), with F(0)=0 and F(1)=F(2)=1.
- `res_n` out 8: index of this result.
- `res_tag` out TAG_W: tag of this result.
- `res_ovf` out 1: result saturated (only with the macro; otherwise 0).
- `gen_rst` out 1: generator synchronous reset, active-high.
- `gen_n` out 8: generator target index.
- `gen_fib` in 32: generator result.
- `gen_data_ready` in 1: generator done (`n_ctr == n`).
- `busy` out 1: FSM not IDLE, or FIFO not empty.

## Operation
- Request push: when `req_valid && req_ready`, push {n, tag}. `req_ready` is low when the FIFO holds DEPTH entries; a full FIFO drops nothing.
- Simultaneous events: push and pop in the same cycle are both honoured; the count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, OUT.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head n < 2: pop; load `res_fib` = n, ovf=0; go to OUT.
  - Head n ≥ 2: pop; load `gen_n` = n; latch n and tag; go to LAUNCH.
- LAUNCH: one cycle; go to WAIT.
- WAIT:
  - `gen_data_ready` is sampled only in this state.
  - When high, capture `gen_fib` into `res_fib` and go to OUT.
  - A stale `data_ready` during LAUNCH is ignored by design.
- OUT:
  - `res_valid` = 1.
  - `res_*` held stable until `res_ready`; then go to IDLE.
  - `res_valid` never drops without a handshake.
- `gen_rst` is 1 in every state except WAIT, so the generator is held in reset while unused.
- `gen_n` is registered and holds its value from LAUNCH through WAIT.
- n = 255 is legal; the generator counts up to it.

## Timing
- Reset values, asserted asynchronously on `rst_n` falling:
  - FIFO empty; FSM in IDLE.
  - `req_ready` = 1, `res_valid` = 0, `res_fib` = 0, `res_n` = 0, `res_tag` = 0, `res_ovf` = 0.
  - `gen_rst` = 1, `gen_n` = 2, `busy` = 0.
- Reset is released synchronously to `clk`, via an external synchroniser.
- Reset mid-operation: in-flight and queued requests are discarded; no result is emitted for them.
- Latency, with the request accepted at edge 0 and the FSM idle with the FIFO empty:
  - n < 2: `res_valid` high after edge 1.
  - n ≥ 2: LAUNCH after edge 1, generator reset at edge 2, `n_ctr` = 2 after edge 2, capture at edge n+1. `res_valid` high after edge n+1.
- Throughput: one result per (latency + 1) cycles. OUT→IDLE is one bubble cycle.

## Configuration
- `FIB_CTRL_SAT_EN` defined:
  - IDLE treats a head entry with n > 47 as a local case: pop, `res_fib` = 32'hFFFF_FFFF, `res_ovf` = 1, go to OUT. The generator is not launched.
  - Latency matches n < 2.
  - F(47) = 2971215073 is the largest value that fits in 32 bits.
- Undefined:
  - n > 47 is launched normally and returns F(n) mod 2^32.
  - `res_ovf` is tied to 0.

## Test plan
- Reset, then n=10, tag=3 -> `res_valid` after edge 11; `res_fib`=55, `res_n`=10, `res_tag`=3, `res_ovf`=0.
- n=0, then n=1, then n=2, with `res_ready`=1 -> results 0, 1, 1 in order; n=0 result after edge 1; `gen_rst` stays high for n=0 and n=1.
- Push 5 requests (n=3..7) while `res_ready`=0 and DEPTH=4 -> `req_ready` drops after 5 accepted (4 in FIFO + 1 in FSM). Release `res_ready` -> results 2, 3, 5, 8, 13 in order. Holding `res_ready` low across OUT keeps `res_*` stable.
- n=48:
  - With `FIB_CTRL_SAT_EN`: `res_fib`=32'hFFFF_FFFF, `res_ovf`=1, after edge 1.
  - Without it: `res_fib`=512559680, `res_ovf`=0.
- n=47 -> `res_fib`=2971215073, `res_ovf`=0 in both builds.
- Assert `rst_n` low during WAIT of n=40 with 2 queued -> all outputs go to reset values immediately; no stale result emitted. Next request n=5 -> 5.

Source files
------------

// File: rtl/fib_req_ctrl.sv
// fib_req_ctrl: request/response front-end for the Fibonacci generator.
// Queues {n, tag} requests in a DEPTH-entry FIFO and runs the generator one
// request at a time (reset, launch, wait for data_ready), then presents the
// result with its index and tag. Indices n < 2 are answered locally.
// Optional build macro FIB_CTRL_SAT_EN: indices n > 47 are answered locally
// with a saturated all-ones result and res_ovf set.
module fib_req_ctrl #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_n,
   input  logic [TAG_W-1:0] req_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_fib,
   output logic [7:0]       res_n,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_ovf,
   output logic             gen_rst,
   output logic [7:0]       gen_n,
   input  logic [31:0]      gen_fib,
   input  logic             gen_data_ready,
   output logic             busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       fifo_n   [DEPTH];
   logic [TAG_W-1:0] fifo_tag [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             empty, push, pop;
   logic [7:0]       head_n;
   logic [TAG_W-1:0] head_tag;
   logic             sat_hit, local_hit;

   assign empty     = (count == '0);
   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign pop       = (state == S_IDLE) && !empty;
   assign head_n    = fifo_n[rd_ptr];
   assign head_tag  = fifo_tag[rd_ptr];

`ifdef FIB_CTRL_SAT_EN
   // Indices above 47 overflow 32 bits; answer them without the generator.
   assign sat_hit = (head_n > 8'd47);
`else
   assign sat_hit = 1'b0;
`endif
   assign local_hit = (head_n < 8'd2) || sat_hit;

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_n[wr_ptr]   <= req_n;
         fifo_tag[wr_ptr] <= req_tag;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic; data_ready only matters while waiting.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!empty) state_nxt = local_hit ? S_OUT : S_LAUNCH;
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT:   if (gen_data_ready) state_nxt = S_OUT;
         S_OUT:    if (res_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; the generator is held in reset whenever it is not counting.
   always_comb begin
      res_valid = (state == S_OUT);
      gen_rst   = (state != S_WAIT);
      busy      = (state != S_IDLE) || !empty;
   end

   // Result and generator-target registers, loaded at pop or at capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_fib <= '0;
         res_n   <= '0;
         res_tag <= '0;
         gen_n   <= 8'd2;
      end else if (pop) begin
         res_n   <= head_n;
         res_tag <= head_tag;
         if (local_hit) res_fib <= sat_hit ? 32'hFFFF_FFFF : {24'd0, head_n};
         else           gen_n   <= head_n;
      end else if (state == S_WAIT && gen_data_ready) begin
         res_fib <= gen_fib;
      end
   end

`ifdef FIB_CTRL_SAT_EN
   // Overflow flag follows the saturating local path only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   res_ovf <= 1'b0;
      else if (pop) res_ovf <= sat_hit;
   end
`else
   assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fib_req_ctrl.sv
// tb_fib_req_ctrl: directed scoreboard bench for fib_req_ctrl with a
// behavioural Fibonacci generator attached to the gen_* side.
module tb_fib_req_ctrl;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
`ifdef FIB_CTRL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid, req_ready, res_valid, res_ready, res_ovf;
   logic [7:0]       req_n, res_n, gen_n;
   logic [TAG_W-1:0] req_tag, res_tag;
   logic [31:0]      res_fib, gen_fib;
   logic             gen_rst, gen_data_ready, busy;

   always #5 clk = ~clk;

   fib_req_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_tag(req_tag),
      .res_valid(res_valid), .res_ready(res_ready), .res_fib(res_fib), .res_n(res_n),
      .res_tag(res_tag), .res_ovf(res_ovf),
      .gen_rst(gen_rst), .gen_n(gen_n), .gen_fib(gen_fib),
      .gen_data_ready(gen_data_ready), .busy(busy)
   );

   // Generator model: sync reset loads F(1), F(2) with n_ctr = 2, counts to gen_n.
   logic [7:0]  g_ctr;
   logic [31:0] g_a, g_b;
   always @(posedge clk) begin
      if (gen_rst) begin
         g_ctr <= 8'd2; g_a <= 32'd1; g_b <= 32'd1;
      end else if (g_ctr != gen_n) begin
         g_ctr <= g_ctr + 8'd1; g_a <= g_b; g_b <= g_a + g_b;
      end
   end
   assign gen_fib        = g_b;
   assign gen_data_ready = (g_ctr == gen_n);

   typedef struct {
      logic [31:0]      fib;
      logic [7:0]       n;
      logic [TAG_W-1:0] tag;
      logic             ovf;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   int nvec = 0;
   int nerr = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // Monitor: compare on handshake; between handshakes outputs must hold.
   logic             hold = 1'b0;
   logic [31:0]      h_fib;
   logic [7:0]       h_n;
   logic [TAG_W-1:0] h_tag;
   logic             h_ovf;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("res_valid_held", res_valid, 1);
            if (res_valid) begin
               chk("res_fib_stable", res_fib, h_fib);
               chk("res_n_stable", res_n, h_n);
               chk("res_tag_stable", res_tag, h_tag);
               chk("res_ovf_stable", res_ovf, h_ovf);
            end
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL unexpected_result: got n=%0d fib=%0d, expected none", res_n, res_fib);
            end else begin
               e = sb.pop_front();
               chk("res_fib", res_fib, e.fib);
               chk("res_n", res_n, e.n);
               chk("res_tag", res_tag, e.tag);
               chk("res_ovf", res_ovf, e.ovf);
            end
            hold = 1'b0;
         end else if (res_valid) begin
            hold = 1'b1;
            h_fib = res_fib; h_n = res_n; h_tag = res_tag; h_ovf = res_ovf;
         end else begin
            hold = 1'b0;
         end
      end
   end

   // Issue one request; the expected result enters the scoreboard on acceptance.
   task automatic send(input logic [7:0] n, input logic [TAG_W-1:0] tag,
                       input logic [31:0] fib, input logic ovf);
      int   t = 0;
      exp_t x;
      req_valid = 1'b1; req_n = n; req_tag = tag;
      while (!req_ready && t < 500) begin
         @(posedge clk); #1; t++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 0, 1);
      end else begin
         @(posedge clk);
         x.fib = fib; x.n = n; x.tag = tag; x.ovf = ovf;
         sb.push_back(x);
      end
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      res_ready = 1'b1;
      while ((sb.size() != 0 || busy || res_valid) && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      chk("drain_done", (t < 3000), 1);
   endtask

   task automatic chk_reset_vals(string tagname);
      chk({tagname, "_req_ready"}, req_ready, 1);
      chk({tagname, "_res_valid"}, res_valid, 0);
      chk({tagname, "_res_fib"}, res_fib, 0);
      chk({tagname, "_res_n"}, res_n, 0);
      chk({tagname, "_res_tag"}, res_tag, 0);
      chk({tagname, "_res_ovf"}, res_ovf, 0);
      chk({tagname, "_gen_rst"}, gen_rst, 1);
      chk({tagname, "_gen_n"}, gen_n, 2);
      chk({tagname, "_busy"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      req_valid = 1'b0; req_n = '0; req_tag = '0; res_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // n=10 latency: valid after edge 11, not after edge 10
      send(8'd10, 4'd3, 32'd55, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("lat10_edge10_valid", res_valid, 0);
      chk("lat10_gen_n", gen_n, 10);
      chk("lat10_gen_rst", gen_rst, 0);
      @(posedge clk); #1;
      chk("lat10_edge11_valid", res_valid, 1);
      drain();

      // n=0,1,2 back to back; local cases keep the generator in reset
      res_ready = 1'b1;
      send(8'd0, 4'd1, 32'd0, 1'b0);
      send(8'd1, 4'd2, 32'd1, 1'b0);
      chk("n0_edge1_valid", res_valid, 1);
      chk("n0_gen_rst", gen_rst, 1);
      send(8'd2, 4'd4, 32'd1, 1'b0);
      chk("bubble_gen_rst", gen_rst, 1);
      @(posedge clk); #1;
      chk("n1_valid", res_valid, 1);
      chk("n1_gen_rst", gen_rst, 1);
      drain();

      // fill: one in the FSM plus DEPTH queued, then backpressure
      res_ready = 1'b0;
      send(8'd3, 4'd3, 32'd2, 1'b0);
      send(8'd4, 4'd4, 32'd3, 1'b0);
      send(8'd5, 4'd5, 32'd5, 1'b0);
      send(8'd6, 4'd6, 32'd8, 1'b0);
      send(8'd7, 4'd7, 32'd13, 1'b0);
      chk("full_req_ready", req_ready, 0);
      chk("full_busy", busy, 1);
      repeat (20) @(posedge clk);
      #1 chk("full_still_full", req_ready, 0);
      drain();

      // n=48: saturates locally, or wraps mod 2^32 through the generator
      res_ready = 1'b0;
      send(8'd48, 4'd5, SAT ? 32'hFFFF_FFFF : 32'd512559680, SAT);
      @(posedge clk); #1;
      chk("n48_edge1_valid", res_valid, SAT);
      drain();

      // n=47: largest 32-bit value, never saturated
      send(8'd47, 4'd6, 32'd2971215073, 1'b0);
      drain();

      // reset during WAIT of n=40 with two queued
      res_ready = 1'b1;
      send(8'd40, 4'd7, 32'd102334155, 1'b0);
      send(8'd3, 4'd8, 32'd2, 1'b0);
      send(8'd4, 4'd9, 32'd3, 1'b0);
      t = 0;
      while (gen_rst && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("rstmid_in_wait", gen_rst, 0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rstmid");
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("rstmid_idle_after", busy, 0);
      send(8'd5, 4'd10, 32'd5, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
